// File: rtl/io_bridge.sv
// Processor I/O bridge: status/RX-FIFO/sampled-input read port, TX-FIFO/control/
// output-register write port, and valid/ready streams on the external side.
module bridge_fifo #(
  parameter int NUBITS = 32,
  parameter int FDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [NUBITS-1:0]         din,
  output logic [NUBITS-1:0]         head,
  output logic [$clog2(FDEPTH):0]   count,
  output logic                      empty,
  output logic                      full
);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;

  logic [NUBITS-1:0] mem_q [FDEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_do, pop_do;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(FDEPTH));
  assign push_do = push && !full;
  assign pop_do  = pop && !empty;
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_q];

  // Flush overrides any same-cycle push/pop and rewinds both pointers.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_do) wr_d = wr_q + 1'b1;
      if (pop_do)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push_do) - CW'(pop_do);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_do) mem_q[wr_q] <= din;
  end
endmodule

module io_bridge #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          data_out,
  input  logic [NUBITS-1:0]          rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [NUBITS-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic [NUIOIN*NUBITS-1:0]   ext_in,
  output logic [NUIOOU*NUBITS-1:0]   out_reg,
  output logic [NUIOOU-1:0]          out_stb
);
  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam int CW  = $clog2(FDEPTH) + 1;

  logic [NUBITS-1:0]        rx_head, ext_sel, status, rd_data;
  logic [CW-1:0]            rx_count, tx_count;
  logic                     rx_empty, rx_full, tx_empty, tx_full;
  logic                     rd_fifo, stat_rd, rx_under, rx_push;
  logic                     ctrl_wr, tx_wr, tx_over, tx_pop;
  logic                     rx_flush, tx_flush, sticky_clr;
  logic                     urf_q, urf_d, ovf_q, ovf_d;
  logic [NUIOIN*NUBITS-1:0] ext_q, ext_d;
  logic [NUIOOU*NUBITS-1:0] out_reg_q, out_reg_d;
  logic [NUIOOU-1:0]        out_stb_q, out_stb_d;

  assign rd_fifo    = req_in && (addr_in == AIW'(1));
  assign stat_rd    = req_in && (addr_in == '0);
  assign rx_under   = rd_fifo && rx_empty;
  assign ctrl_wr    = out_en && (addr_out == '0);
  assign tx_wr      = out_en && (addr_out == AOW'(1));
  assign tx_over    = tx_wr && tx_full;
  assign rx_flush   = ctrl_wr && data_out[0];
  assign tx_flush   = ctrl_wr && data_out[1];
  assign sticky_clr = stat_rd || (ctrl_wr && data_out[2]);

  // Handshakes are gated by reset so the streams are idle while it is held.
  assign rx_ready = rst && !rx_full;
  assign tx_valid = rst && !tx_empty;
  assign rx_push  = rx_valid && rx_ready;
  assign tx_pop   = tx_valid && tx_ready;

  bridge_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rd_fifo), .flush(rx_flush),
    .din(rx_data), .head(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );

  bridge_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_wr), .pop(tx_pop), .flush(tx_flush),
    .din(data_out), .head(tx_data), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );

  always_comb begin
    status        = '0;
    status[0]     = rx_empty;
    status[1]     = rx_full;
    status[2]     = tx_empty;
    status[3]     = tx_full;
    status[4]     = urf_q;
    status[5]     = ovf_q;
    status[15:8]  = 8'(rx_count);
    status[23:16] = 8'(tx_count);
  end

  always_comb begin
    ext_sel = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (addr_in == AIW'(k)) ext_sel = ext_q[k*NUBITS +: NUBITS];
    end
    if (addr_in == '0)          rd_data = status;
    else if (addr_in == AIW'(1)) rd_data = rx_head;
    else                         rd_data = ext_sel;
  end

  assign io_in = req_in ? rd_data : '0;

  // A fresh underflow/overflow event outranks a same-cycle clear.
  always_comb begin
    urf_d = urf_q;
    ovf_d = ovf_q;
    if (sticky_clr) begin
      urf_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (rx_under) urf_d = 1'b1;
    if (tx_over)  ovf_d = 1'b1;
  end

  always_comb begin
    ext_d     = ext_in;
    out_reg_d = out_reg_q;
    out_stb_d = '0;
    for (int k = 2; k < NUIOOU; k++) begin
      if (out_en && (addr_out == AOW'(k))) begin
        out_reg_d[k*NUBITS +: NUBITS] = data_out;
        out_stb_d[k]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      urf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ext_q     <= '0;
      out_reg_q <= '0;
      out_stb_q <= '0;
    end else begin
      urf_q     <= urf_d;
      ovf_q     <= ovf_d;
      ext_q     <= ext_d;
      out_reg_q <= out_reg_d;
      out_stb_q <= out_stb_d;
    end
  end

  assign out_reg = out_reg_q;
  assign out_stb = out_stb_q;
endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: RX/TX expectations are queued as stimulus is
// driven and compared when the processor reads or the TX stream drains.
module tb_io_bridge;
  localparam int NB = 32;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int FD = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_in = 1'b0;
  logic [2:0]       addr_in = '0;
  logic [NB-1:0]    io_in;
  logic             out_en = 1'b0;
  logic [2:0]       addr_out = '0;
  logic [NB-1:0]    data_out = '0;
  logic [NB-1:0]    rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic [NB-1:0]    tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [NI*NB-1:0] ext_in = '0;
  logic [NO*NB-1:0] out_reg;
  logic [NO-1:0]    out_stb;

  int checks = 0;
  int failures = 0;
  logic [31:0] rx_exp[$];
  logic [31:0] tx_exp[$];
  bit uf_m = 1'b0;
  bit of_m = 1'b0;
  logic [31:0] d;

  io_bridge #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ext_in(ext_in), .out_reg(out_reg), .out_stb(out_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int rxc, input int txc, input bit uf, input bit ovf);
    logic [31:0] s;
    s        = '0;
    s[0]     = (rxc == 0);
    s[1]     = (rxc == FD);
    s[2]     = (txc == 0);
    s[3]     = (txc == FD);
    s[4]     = uf;
    s[5]     = ovf;
    s[15:8]  = rxc[7:0];
    s[23:16] = txc[7:0];
    return s;
  endfunction

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    req_in  = 1'b1;
    addr_in = a;
    #1 v = io_in;
    @(posedge clk);
    #1 req_in = 1'b0;
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] v;
    rd(3'd0, v);
    chk(tag, v, exp_stat(rx_exp.size(), tx_exp.size(), uf_m, of_m));
    uf_m = 1'b0;
    of_m = 1'b0;
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    rd(3'd1, v);
    if (rx_exp.size() == 0) begin
      e    = '0;
      uf_m = 1'b1;
    end else begin
      e = rx_exp.pop_front();
    end
    chk(tag, v, e);
  endtask

  task automatic push_rx(input logic [31:0] v);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = v;
    #1 chk("rx_ready", 32'(rx_ready), 32'(rx_exp.size() < FD));
    if (rx_exp.size() < FD) rx_exp.push_back(v);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    out_en   = 1'b1;
    addr_out = a;
    data_out = v;
    if (a == 3'd1) begin
      if (tx_exp.size() < FD) tx_exp.push_back(v);
      else of_m = 1'b1;
    end
    if (a == 3'd0) begin
      if (v[0]) rx_exp.delete();
      if (v[1]) tx_exp.delete();
      if (v[2]) begin
        uf_m = 1'b0;
        of_m = 1'b0;
      end
    end
    @(posedge clk);
    #1 out_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_out_stb", 32'(out_stb), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd_status("status_after_reset");
    #1;
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);

    // RX fill to full, overflow attempt, drain, underflow
    for (int i = 0; i < 9; i++) push_rx(32'h11 + 32'(i));
    #1 chk("rx_ready_full", 32'(rx_ready), 32'd0);
    rd_status("status_rx_full");
    for (int i = 0; i < 9; i++) rd_rx("rx_read");
    rd_status("status_underflow");
    rd_status("status_uf_cleared");

    // TX overfill with the sink stalled, then drain
    for (int i = 0; i < 9; i++) wr(3'd1, 32'hA0 + 32'(i));
    rd_status("status_tx_full");
    for (int i = 0; i < FD; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk("tx_data", tx_data, tx_exp.pop_front());
    end
    @(negedge clk);
    #1 chk("tx_drained", 32'(tx_valid), 32'd0);
    chk("tx_data_empty", tx_data, 32'd0);
    tx_ready = 1'b0;

    // Output registers and strobes
    wr(3'd5, 32'h12345678);
    chk("stb5", 32'(out_stb), 32'h20);
    wr(3'd3, 32'hDEADBEEF);
    chk("stb3", 32'(out_stb), 32'h08);
    chk("out_reg3", out_reg[3*NB +: NB], 32'hDEADBEEF);
    chk("out_reg5", out_reg[5*NB +: NB], 32'h12345678);
    chk("out_reg0", out_reg[0 +: NB], 32'd0);
    chk("out_reg1", out_reg[NB +: NB], 32'd0);
    @(posedge clk);
    #1 chk("stb_one_cycle", 32'(out_stb), 32'd0);
    chk("out_reg3_hold", out_reg[3*NB +: NB], 32'hDEADBEEF);

    // Sampled static inputs are one cycle old; io_in is 0 without req_in
    @(negedge clk);
    ext_in[4*NB +: NB] = 32'hCAFE0004;
    addr_in = 3'd4;
    @(negedge clk);
    ext_in[4*NB +: NB] = 32'hBEEF0004;
    #1 chk("io_in_idle", io_in, 32'd0);
    req_in = 1'b1;
    #1 chk("ext_old_sample", io_in, 32'hCAFE0004);
    @(posedge clk);
    #1 req_in = 1'b0;
    rd(3'd4, d);
    chk("ext_new_sample", d, 32'hBEEF0004);

    // Simultaneous push and pop on non-empty RX
    push_rx(32'h21);
    push_rx(32'h22);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 32'h23;
    req_in   = 1'b1;
    addr_in  = 3'd1;
    #1 chk("pushpop_head", io_in, rx_exp.pop_front());
    rx_exp.push_back(32'h23);
    @(posedge clk);
    #1 begin
      rx_valid = 1'b0;
      req_in   = 1'b0;
    end
    rd_status("status_pushpop");
    rd_rx("rx_after_pushpop");
    rd_rx("rx_after_pushpop");

    // Pop of empty RX in the same cycle as a push: push only
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 32'h77;
    req_in   = 1'b1;
    addr_in  = 3'd1;
    #1 chk("empty_pop_data", io_in, 32'd0);
    uf_m = 1'b1;
    rx_exp.push_back(32'h77);
    @(posedge clk);
    #1 begin
      rx_valid = 1'b0;
      req_in   = 1'b0;
    end
    rd_status("status_push_only");
    rd_rx("rx_push_only");

    // Control write clears sticky bits
    rd_rx("rx_underflow_again");
    wr(3'd0, 32'h4);
    rd_status("status_ctrl_clear");

    // Flush outranks same-cycle push and pop
    for (int i = 0; i < 4; i++) push_rx(32'h31 + 32'(i));
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 32'h35;
    req_in   = 1'b1;
    addr_in  = 3'd1;
    out_en   = 1'b1;
    addr_out = 3'd0;
    data_out = 32'h1;
    #1 chk("flush_head", io_in, 32'h31);
    rx_exp.delete();
    @(posedge clk);
    #1 begin
      rx_valid = 1'b0;
      req_in   = 1'b0;
      out_en   = 1'b0;
    end
    rd_status("status_after_flush");
    push_rx(32'h41);
    rd_rx("rx_after_flush");

    // Reset mid-operation discards TX contents
    for (int i = 0; i < 3; i++) wr(3'd1, 32'hB0 + 32'(i));
    #1 chk("tx_valid_pre_rst", 32'(tx_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tx_valid_in_rst", 32'(tx_valid), 32'd0);
    chk("rx_ready_in_rst", 32'(rx_ready), 32'd0);
    chk("out_reg3_in_rst", out_reg[3*NB +: NB], 32'd0);
    tx_exp.delete();
    @(negedge clk);
    rst = 1'b1;
    rd_status("status_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter NUBITS, default 32, data word width; minimum 24.
REQ-002 SHALL have parameter NUIOIN, default 8, number of processor input addresses; minimum 3.
REQ-003 SHALL have parameter NUIOOU, default 8, number of processor output addresses; minimum 3.
REQ-004 SHALL have parameter FDEPTH, default 8, entries per FIFO; power of two, 2..128.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_in, input, 1, processor input-read request.
REQ-008 SHALL have port addr_in, input, clog2(NUIOIN), processor read address.
REQ-009 SHALL have port io_in, output, NUBITS, read data to processor.
REQ-010 SHALL have port out_en, input, 1, processor write strobe.
REQ-011 SHALL have port addr_out, input, clog2(NUIOOU), processor write address.
REQ-012 SHALL have port data_out, input, NUBITS, processor write data.
REQ-013 SHALL have ports rx_data (input, NUBITS), rx_valid (input, 1) and rx_ready (output, 1), forming the external-to-processor stream.
REQ-014 SHALL have ports tx_data (output, NUBITS), tx_valid (output, 1) and tx_ready (input, 1), forming the processor-to-external stream.
REQ-015 SHALL have port ext_in, input, NUIOIN*NUBITS, static input words; slice k belongs to input address k.
REQ-016 SHALL have port out_reg, output, NUIOOU*NUBITS, registered output words; slice k belongs to output address k.
REQ-017 SHALL have port out_stb, output, NUIOOU, one-cycle write strobe per output address.

Function
REQ-018 SHALL drive io_in combinationally from addr_in while req_in=1, and drive 0 while req_in=0.
REQ-019 SHALL return, at addr_in 0, the status word: bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_underflow (sticky), bit5 tx_overflow (sticky), [15:8] rx_count, [23:16] tx_count, other bits 0.
REQ-020 SHALL return the RX FIFO head at addr_in 1, and pop it on the rising edge where req_in=1, addr_in=1 and the FIFO is not empty.
REQ-021 SHALL, on an addr_in 1 read while RX is empty, return 0, not pop, and set rx_underflow.
REQ-022 SHALL return a per-cycle registered sample of ext_in slice k at addr_in k>=2; read data is one cycle old.
REQ-023 SHALL clear both sticky bits on the edge following a status read (req_in=1, addr_in=0).
REQ-024 SHALL, on out_en=1 with addr_out 1, push data_out into TX when TX is not full; when full, the word is dropped and tx_overflow is set. A pop in the same cycle does not make room.
REQ-025 SHALL treat out_en=1 with addr_out 0 as a control write: bit0 flushes RX, bit1 flushes TX, bit2 clears both sticky bits.
REQ-026 SHALL treat out_en=1 with addr_out k>=2 as: out_reg[k] <= data_out, and out_stb[k]=1 for exactly the next cycle.
REQ-027 SHALL hold out_reg and out_stb slices 0 and 1 at 0.
REQ-028 SHALL drive rx_ready = NOT rx_full; RX pushes on rx_valid AND rx_ready.
REQ-029 SHALL drive tx_valid = NOT tx_empty and tx_data = TX head (0 when empty); TX pops on tx_valid AND tx_ready.
REQ-030 SHALL, on a simultaneous push and pop on a non-empty FIFO, perform both and leave its count unchanged.
REQ-031 SHALL, on a pop request to an empty FIFO in the same cycle as a push, perform the push only.
REQ-032 SHALL give flush priority over a same-cycle push and pop: count becomes 0 and pointers return to 0.
REQ-033 SHALL let pointers wrap modulo FDEPTH; count ranges 0..FDEPTH, with full meaning count=FDEPTH.

Reset
REQ-034 SHALL, while rst=0, clear both FIFO counts and pointers, sticky bits, sampled ext_in registers, out_reg and out_stb, and force rx_ready=0 and tx_valid=0.
REQ-035 SHALL discard in-flight FIFO contents when rst is asserted mid-operation; after release, status reads 0x00000005.

Verification
REQ-036 Reset, then read addr 0 -> io_in=0x00000005, rx_ready=1, tx_valid=0.
REQ-037 Push 8 RX words 0x11..0x18 with FDEPTH=8 -> rx_ready=0 after the 8th; a 9th word is not accepted; eight addr-1 reads return 0x11..0x18 in order; a 9th read returns 0 and status bit4=1, cleared after that status read.
REQ-038 Write 9 words to addr_out 1 with tx_ready=0 -> tx_count=8, bit5=1; the 9th word is absent; raising tx_ready drains 8 words in order, one per cycle.
REQ-039 Write 0xDEADBEEF to addr_out 3 -> out_reg[3]=0xDEADBEEF and out_stb=0b00001000 for one cycle; other slices unchanged.
REQ-040 RX at count 4 with push, pop and a control flush (bit0) in the same cycle -> rx_count=0 and rx_empty=1.
REQ-041 Assert rst low while TX holds 3 words -> tx_valid=0 immediately; after release, tx_count=0.
